// File: rtl/lsu_pkg.sv
// Load/store unit shared definitions: FSM state encoding, funct3 access
// codes, fault codes and request-legality helpers used at request accept.
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_ILLEGAL  = 2'b10;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

    // Stores have no unsigned variants, so only B/H/W are legal for them.
    function automatic logic funct3_legal(input logic       store,
                                          input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        unique case (1'b1)
            (f3 == F3_B), (f3 == F3_H), (f3 == F3_W): ok = 1'b1;
            (f3 == F3_BU), (f3 == F3_HU):             ok = ~store;
            default:                                  ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3,
                                        input logic [1:0] addr_lo);
        logic m;
        m = 1'b0;
        unique case (f3[1:0])
            2'b01:   m = addr_lo[0];
            2'b10:   m = |addr_lo;
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: byte enables and store replication toward memory,
// plus lane selection and sign/zero extension of returned load data.
// Ports: addr_lo_i/funct3_i select the access; wdata_i/rdata_i raw data;
// byte_en_o, wdata_o (replicated store data), rdata_o (extended load).
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  byte_en_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        byte_en_o = 4'b1111;
        wdata_o   = wdata_i;
        unique case (funct3_i[1:0])
            2'b00: begin
                byte_en_o = 4'b0001 << addr_lo_i;
                wdata_o   = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                byte_en_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o   = {2{wdata_i[15:0]}};
            end
            default: begin
                byte_en_o = 4'b1111;
                wdata_o   = wdata_i;
            end
        endcase
    end

    always_comb begin
        lane_b = rdata_i[7:0];
        unique case (addr_lo_i)
            2'd0:    lane_b = rdata_i[7:0];
            2'd1:    lane_b = rdata_i[15:8];
            2'd2:    lane_b = rdata_i[23:16];
            default: lane_b = rdata_i[31:24];
        endcase
        lane_h = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        rdata_o = rdata_i;
        unique case (funct3_i)
            F3_B:    rdata_o = {{24{lane_b[7]}}, lane_b};
            F3_H:    rdata_o = {{16{lane_h[15]}}, lane_h};
            F3_BU:   rdata_o = {24'b0, lane_b};
            F3_HU:   rdata_o = {16'b0, lane_h};
            default: rdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request in IDLE, checks legality/alignment,
// runs a single memory access with ack timeout, then pulses a response.
// Ports: clk/reset; req_* request handshake; resp_* response pulse;
// mem_* word-aligned memory access, mem_ack/mem_read_data from memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_base,
    input  logic [31:0] req_offset,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_fault,
    output logic [31:0] mem_address,
    output logic        mem_read_enable,
    output logic        mem_write_enable,
    output logic [3:0]  mem_byte_en,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    input  logic        mem_ack
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e    state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          store_q, store_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [1:0]    fault_q, fault_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [31:0]   req_addr;
    logic          in_access;
    logic          last_cycle;
    logic [3:0]    al_be;
    logic [31:0]   al_wdata;
    logic [31:0]   al_rdata;

    assign req_addr   = req_base + req_offset;
    assign in_access  = (state_q == S_ACCESS);
    // cnt_q counts completed ACCESS cycles; this is the last one allowed.
    assign last_cycle = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    lsu_lane_align u_align (
        .addr_lo_i (addr_q[1:0]),
        .funct3_i  (funct3_q),
        .wdata_i   (wdata_q),
        .rdata_i   (mem_read_data),
        .byte_en_o (al_be),
        .wdata_o   (al_wdata),
        .rdata_o   (al_rdata)
    );

    assign req_ready        = (state_q == S_IDLE);
    assign resp_valid       = (state_q == S_RESP);
    assign resp_rdata       = resp_valid ? rdata_q : 32'h0;
    assign resp_fault       = resp_valid ? fault_q : FAULT_NONE;
    assign mem_address      = in_access ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_read_enable  = in_access & ~store_q;
    assign mem_write_enable = in_access & store_q;
    assign mem_byte_en      = in_access ? al_be : 4'b0000;
    assign mem_write_data   = (in_access & store_q) ? al_wdata : 32'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            store_q  <= 1'b0;
            funct3_q <= '0;
            fault_q  <= FAULT_NONE;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            store_q  <= store_d;
            funct3_q <= funct3_d;
            fault_q  <= fault_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        store_d  = store_q;
        funct3_d = funct3_q;
        fault_d  = fault_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    rdata_d = '0;
                    if (!funct3_legal(req_store, req_funct3)) begin
                        fault_d = FAULT_ILLEGAL;
                        state_d = S_RESP;
                    end else if (misaligned(req_funct3, req_addr[1:0])) begin
                        fault_d = FAULT_MISALIGN;
                        state_d = S_RESP;
                    end else begin
                        addr_d   = req_addr;
                        wdata_d  = req_wdata;
                        store_d  = req_store;
                        funct3_d = req_funct3;
                        fault_d  = FAULT_NONE;
                        cnt_d    = '0;
                        state_d  = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                // Ack is checked first so it wins in the final cycle.
                if (mem_ack) begin
                    rdata_d = store_q ? 32'h0 : al_rdata;
                    fault_d = FAULT_NONE;
                    state_d = S_RESP;
                end else if (last_cycle) begin
                    rdata_d = '0;
                    fault_d = FAULT_TIMEOUT;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: randomized requests, reference
// model derived from address arithmetic, monitor comparing every response.
module tb_load_store_unit;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_base;
    logic [31:0] req_offset;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_fault;
    logic [31:0] mem_address;
    logic        mem_read_enable;
    logic        mem_write_enable;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_ack;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_store        (req_store),
        .req_funct3       (req_funct3),
        .req_base         (req_base),
        .req_offset       (req_offset),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_fault       (resp_fault),
        .mem_address      (mem_address),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .mem_byte_en      (mem_byte_en),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data),
        .mem_ack          (mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  fault;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic exp_access = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, want);
        end
    endtask

    // Reference: size from funct3[1:0], lanes from address modulo 4.
    task automatic model(input logic st, input logic [2:0] f3,
                         input logic [31:0] a, wd, rd, input int k,
                         output logic [1:0] fault, output logic [31:0] rdata,
                         output int lat, output logic [3:0] be,
                         output logic [31:0] wrep);
        int          size;
        int          off;
        logic        legal;
        logic [31:0] mask;
        logic [31:0] v;
        size  = 1 << f3[1:0];
        off   = int'(a[1:0]);
        be    = 4'(((1 << size) - 1) << off);
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        mask  = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        v     = (rd >> (8 * off)) & mask;
        if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | ~mask;
        if (size == 1)      wrep = wd[7:0] * 32'h0101_0101;
        else if (size == 2) wrep = wd[15:0] * 32'h0001_0001;
        else                wrep = wd;
        rdata = 32'h0;
        if (!legal) begin
            fault = 2'b10;
            lat   = 1;
        end else if ((off % size) != 0) begin
            fault = 2'b01;
            lat   = 1;
        end else if (k >= TO) begin
            fault = 2'b11;
            lat   = TO + 1;
        end else begin
            fault = 2'b00;
            lat   = k + 2;
            if (!st) rdata = v;
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", 32'(req_ready), 32'd1);
    endtask

    task automatic do_txn(input logic st, input logic [2:0] f3,
                          input logic [31:0] base, off, wd, rd, input int k);
        logic [31:0] a;
        logic [1:0]  ef;
        logic [31:0] er;
        logic [31:0] ewr;
        logic [3:0]  ebe;
        int          el;
        exp_t        e;
        a = base + off;
        model(st, f3, a, wd, rd, k, ef, er, el, ebe, ewr);
        wait_ready();
        req_valid     = 1'b1;
        req_store     = st;
        req_funct3    = f3;
        req_base      = base;
        req_offset    = off;
        req_wdata     = wd;
        mem_read_data = rd;
        mem_ack       = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_base   = $urandom;
        req_offset = $urandom;
        req_wdata  = $urandom;
        e.rdata = er;
        e.fault = ef;
        e.lat   = el;
        e.acc   = cyc;
        q.push_back(e);
        if (ef == 2'b00 || ef == 2'b11) begin
            exp_access = 1'b1;
            for (int j = 0; j < TO; j++) begin
                mem_ack = (j == k);
                @(negedge clk);
                chk("mem_address", mem_address, {a[31:2], 2'b00});
                chk("mem_byte_en", 32'(mem_byte_en), 32'(ebe));
                chk("mem_read_enable", 32'(mem_read_enable), 32'(!st));
                chk("mem_write_enable", 32'(mem_write_enable), 32'(st));
                if (st) chk("mem_write_data", mem_write_data, ewr);
                @(posedge clk);
                #1;
                if (j == k) break;
            end
            exp_access = 1'b0;
        end
        mem_ack = 1'($urandom_range(0, 1));
    endtask

    // Monitor: pops one expectation per response pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (resp_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got fault %0d rdata 0x%08h expected no response",
                             resp_fault, resp_rdata);
                end else begin
                    e = q.pop_front();
                    chk("resp_fault", 32'(resp_fault), 32'(e.fault));
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                end
            end
            chk("mem_enable_window", 32'(mem_read_enable | mem_write_enable),
                32'(exp_access));
        end
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        chk({tag, "_resp_fault"}, 32'(resp_fault), 32'd0);
        chk({tag, "_mem_address"}, mem_address, 32'd0);
        chk({tag, "_mem_en"}, 32'({mem_read_enable, mem_write_enable}), 32'd0);
        chk({tag, "_mem_byte_en"}, 32'(mem_byte_en), 32'd0);
        chk({tag, "_mem_wdata"}, mem_write_data, 32'd0);
    endtask

    initial begin
        logic        st;
        logic [2:0]  f3;
        logic [31:0] base;
        logic [31:0] off;
        int          o;
        int          r;
        int          k;
        int          n;

        reset         = 1'b1;
        req_valid     = 1'b0;
        req_store     = 1'b0;
        req_funct3    = 3'd0;
        req_base      = 32'h0;
        req_offset    = 32'h0;
        req_wdata     = 32'h0;
        mem_read_data = 32'h0;
        mem_ack       = 1'b1;
        #12;
        check_idle_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        do_txn(1'b1, 3'b010, 32'h100, 32'h14, 32'hDEAD_BEEF, 32'h0, 0);
        do_txn(1'b0, 3'b000, 32'h10, 32'h7, 32'h0, 32'h80FF_0000, 1);
        do_txn(1'b0, 3'b100, 32'h10, 32'h7, 32'h0, 32'h80FF_0000, 2);
        do_txn(1'b0, 3'b001, 32'h100, 32'h1, 32'h0, 32'h0, 0);
        do_txn(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 32'h0, 0);
        do_txn(1'b0, 3'b111, 32'h100, 32'h1, 32'h0, 32'h0, 0);
        do_txn(1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 32'h0, 0);
        do_txn(1'b1, 3'b001, 32'h20, 32'h2, 32'h1234_ABCD, 32'h0, 3);
        do_txn(1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 32'h1357_9BDF, TO);
        do_txn(1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 32'h1357_9BDF, TO - 1);
        do_txn(1'b0, 3'b101, 32'h10, 32'hFFFF_FFF6, 32'h0, 32'hBEEF_8001, 0);
        do_txn(1'b0, 3'b001, 32'hFFFF_FFFE, 32'h4, 32'h0, 32'h0000_F00D, 0);

        for (int i = 0; i < 150; i++) begin
            st   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            base = $urandom;
            o    = int'($urandom_range(0, 63)) - 32;
            off  = 32'(o);
            if ($urandom_range(0, 2) != 0) begin
                base[1:0] = 2'b00;
                off[1:0]  = 2'b00;
            end
            r = int'($urandom_range(0, 9));
            if (r < 7)       k = int'($urandom_range(0, 4));
            else if (r == 7) k = TO - 1;
            else if (r == 8) k = TO;
            else             k = int'($urandom_range(5, 14));
            do_txn(st, f3, base, off, $urandom, $urandom, k);
        end

        // Reset in the third ACCESS cycle drops the transaction silently.
        wait_ready();
        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = 3'b010;
        req_base   = 32'h40;
        req_offset = 32'h0;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        mem_ack    = 1'b0;
        exp_access = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre_reset_read_enable", 32'(mem_read_enable), 32'd1);
        exp_access = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        check_idle_outputs("midreset");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        do_txn(1'b1, 3'b000, 32'h200, 32'h3, 32'h0000_00A5, 32'h0, 1);

        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, is the maximum number of ACCESS cycles spent waiting for mem_ack before a timeout fault.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  core presents a load/store request.
REQ-005 req_ready  output  1  unit accepts a request; high only in IDLE.
REQ-006 req_store  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  access type: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010.
REQ-008 req_base  input  32  base register value.
REQ-009 req_offset  input  32  sign-extended immediate.
REQ-010 req_wdata  input  32  store source register value.
REQ-011 resp_valid  output  1  one-cycle pulse marking response completion.
REQ-012 resp_rdata  output  32  extended load result; 0 for stores and faults.
REQ-013 resp_fault  output  2  00 none, 01 misaligned, 10 illegal funct3, 11 timeout.
REQ-014 mem_address  output  32  word-aligned address, {addr[31:2],2'b00}.
REQ-015 mem_read_enable  output  1  load access active.
REQ-016 mem_write_enable  output  1  store access active.
REQ-017 mem_byte_en  output  4  lane enables, bit i = byte i.
REQ-018 mem_write_data  output  32  lane-replicated store data.
REQ-019 mem_read_data  input  32  word returned by memory.
REQ-020 mem_ack  input  1  memory completes the current access.

Function
REQ-021 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-022 In IDLE with req_valid high: addr = req_base + req_offset mod 2^32, with the carry discarded.
REQ-023 Illegal funct3 (load 011/110/111; store >= 011) SHALL go to RESP with fault 10, with no memory access.
REQ-024 Misalignment (halfword with addr[0]=1; word with addr[1:0]!=00) SHALL go to RESP with fault 01, with no memory access; illegal takes priority over misaligned.
REQ-025 A legal request SHALL latch addr, type and data, then go to ACCESS.
REQ-026 In ACCESS, the mem_* outputs SHALL be driven constant from registered state for every cycle of the state.
REQ-027 Byte enables: B gives 1<<addr[1:0]; H gives 0011 when addr[1]=0, else 1100; W gives 1111. Loads drive byte enables identically.
REQ-028 Store data: SB replicates byte[7:0] to all four lanes, SH replicates half[15:0] to both halves, SW passes the word unchanged.
REQ-029 mem_ack high in ACCESS SHALL register the load lane and go to RESP, fault 00.
REQ-030 Load extraction SHALL select the lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes unchanged.
REQ-031 A cycle counter SHALL clear on ACCESS entry. If TIMEOUT_CYCLES ACCESS cycles elapse without mem_ack, the FSM SHALL go to RESP with fault 11.
REQ-032 mem_ack arriving in the final allowed ACCESS cycle SHALL complete normally; ack wins over timeout.
REQ-033 RESP SHALL assert resp_valid for exactly one cycle, then return to IDLE; a new request is accepted in the following cycle.
REQ-034 Latency, measured from the acceptance edge: fault response 1 cycle; memory response (k+2) cycles, where k = ACCESS cycles before mem_ack (k=0 means mem_ack arrived in the first ACCESS cycle).
REQ-035 mem_ack outside ACCESS SHALL be ignored.
REQ-036 mem_read_enable, mem_write_enable and mem_byte_en SHALL be 0 outside ACCESS.

Reset
REQ-037 Reset SHALL force IDLE and clear the counter and all latched request state.
REQ-038 Every output SHALL be 0 during reset except req_ready, which SHALL be 1.
REQ-039 Reset in ACCESS or RESP SHALL drop the transaction with no response pulse.

Structure
REQ-040 Package lsu_pkg SHALL hold the state enum, funct3 constants and fault-code constants.
REQ-041 Combinational sub-module lsu_lane_align SHALL generate byte enables and store replication, and perform load extraction.

Verification
REQ-042 Scenario: SW base 0x100, offset 0x14, data 0xDEADBEEF, ack at k=0 -> mem_address 0x114, byte_en 1111, resp_valid 2 cycles after acceptance, fault 00.
REQ-043 Scenario: LB addr 0x17, mem_read_data 0x80FF_0000 -> byte_en 1000, resp_rdata 0xFFFFFF80; same access as LBU -> 0x00000080.
REQ-044 Scenario: LH addr 0x101 -> resp_valid 1 cycle after acceptance, fault 01, read/write enables never asserted; load funct3 011 -> fault 10.
REQ-045 Scenario: SH addr 0x22, data 0x1234ABCD -> byte_en 1100, mem_write_data 0xABCDABCD.
REQ-046 Scenario: LW with mem_ack never asserted, TIMEOUT_CYCLES=16 -> fault 11 after 16 ACCESS cycles; repeat with ack in cycle 16 -> fault 00.
REQ-047 Scenario: reset asserted in the 3rd ACCESS cycle -> no resp_valid pulse, req_ready=1, all mem enables 0 immediately.
